// File: rtl/shifter_feed_pkg.sv
// Shared definitions for the shifter word feeder: resolution codes,
// fetch FSM states and the bitplane group size per resolution.
package shifter_feed_pkg;

  localparam logic [1:0] REZ_LOW  = 2'd0;
  localparam logic [1:0] REZ_MID  = 2'd1;
  localparam logic [1:0] REZ_HIGH = 2'd2;

  // plane counter width; holds 0..3 and the transient value 4
  localparam int PLANE_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    LOADH = 2'd2
  } state_t;

  // Number of bitplane words that make up one shifter group.
  function automatic logic [PLANE_W-1:0] group_size(input logic [1:0] rez);
    logic [PLANE_W-1:0] g;
    case (rez)
      REZ_LOW: g = 3'd4;
      REZ_MID: g = 3'd2;
      default: g = 3'd1;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/shifter_feed_addr.sv
// Video address counter: per-word increment, end-of-line offset add and
// frame base reload. Reload and line-end updates only happen while the
// fetch FSM is idle, and reload takes priority over the line offset.
module shifter_feed_addr
  import shifter_feed_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int OFS_W  = 8
) (
  input  logic              clk32,
  input  logic              nReset,
  input  logic              idle,
  input  logic              word_done,
  input  logic              line_idle,
  input  logic              vsync,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [OFS_W-1:0]  line_offset,
  output logic [ADDR_W-1:0] vaddr,
  output logic              reload_now
);

  logic vsync_d;
  logic reload_pend;
  logic line_pend;
  logic line_end;
  logic vsync_rise;

  assign vsync_rise = vsync & ~vsync_d;
  assign reload_now = idle & reload_pend;
  // the offset is skipped entirely when a reload is due in the same cycle
  assign line_end   = idle & ~reload_pend & line_idle & line_pend;

  // delayed vsync for rising-edge detection
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) vsync_d <= 1'b0;
    else         vsync_d <= vsync;
  end

  // frame reload request, held until the FSM is idle
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      reload_pend <= 1'b0;
    end else if (vsync_rise) begin
      reload_pend <= 1'b1;
    end else if (reload_now) begin
      reload_pend <= 1'b0;
    end
  end

  // a line is pending once any word has been fetched since the last line end
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      line_pend <= 1'b0;
    end else if (reload_now || line_end) begin
      line_pend <= 1'b0;
    end else if (word_done) begin
      line_pend <= 1'b1;
    end
  end

  // video address: base reload, line offset, or per-word increment (wraps)
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      vaddr <= '0;
    end else if (reload_now) begin
      vaddr <= base_addr;
    end else if (line_end) begin
      vaddr <= vaddr + ADDR_W'(line_offset);
    end else if (word_done) begin
      vaddr <= vaddr + ADDR_W'(1);
    end
  end

endmodule

// File: rtl/shifter_feed.sv
// Shifter word feeder: on each video bus slot, fetches one bitplane word
// from RAM at the video address and presents it to the shifter with a
// LOAD pulse. Completes partial bitplane groups, adds the hard-scroll
// extra group and flags slots that arrive while a fetch is in flight.
module shifter_feed
  import shifter_feed_pkg::*;
#(
  parameter int ADDR_W     = 23,
  parameter int LOAD_WIDTH = 4,
  parameter int OFS_W      = 8
) (
  input  logic              clk32,
  input  logic              nReset,
  input  logic              slot_en,
  input  logic              fetch_en,
  input  logic              vsync,
  input  logic [1:0]        rez,
  input  logic              scroll,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [OFS_W-1:0]  line_offset,
  output logic              ram_req,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic              ram_ack,
  input  logic [15:0]       ram_data,
  output logic              LOAD,
  output logic [15:0]       DOUT,
  output logic [ADDR_W-1:0] vaddr,
  output logic              underrun
);

  localparam int LCNT_W = (LOAD_WIDTH > 1) ? $clog2(LOAD_WIDTH) : 1;

  state_t state;
  state_t state_nx;

  logic               fetch_en_d;
  logic               extra_pend;
  logic               extra_grp;
  logic [PLANE_W-1:0] plane_cnt;
  logic [PLANE_W-1:0] grp;
  logic [PLANE_W-1:0] plane_base;
  logic [PLANE_W-1:0] plane_inc;
  logic [PLANE_W-1:0] plane_nx;
  logic [LCNT_W-1:0]  load_cnt;

  logic group_open;
  logic ack;
  logic wrap;
  logic start_extra;
  logic load_last;
  logic fetch_fall;
  logic line_idle;
  logic reload_now;
  logic idle;

  // A plane count at or above the current group size (after a rez change)
  // counts as a finished group, so the next word starts a fresh one.
  assign grp         = group_size(rez);
  assign group_open  = (plane_cnt != '0) && (plane_cnt < grp);
  assign plane_base  = group_open ? plane_cnt : '0;
  assign plane_inc   = plane_base + PLANE_W'(1);
  assign plane_nx    = (plane_inc >= grp) ? '0 : plane_inc;
  assign wrap        = (plane_nx == '0);

  assign ack         = (state == REQ) & ram_ack;
  assign idle        = (state == IDLE);
  assign fetch_fall  = fetch_en_d & ~fetch_en;
  // first word of the scroll extra group: nothing open and the window closed
  assign start_extra = extra_pend & ~fetch_en & (plane_base == '0);
  assign load_last   = (load_cnt == LCNT_W'(LOAD_WIDTH - 1));
  assign line_idle   = ~fetch_en_d & ~group_open & ~extra_pend;
  assign ram_addr    = vaddr;

  shifter_feed_addr #(
    .ADDR_W (ADDR_W),
    .OFS_W  (OFS_W)
  ) u_addr (
    .clk32       (clk32),
    .nReset      (nReset),
    .idle        (idle),
    .word_done   (ack),
    .line_idle   (line_idle),
    .vsync       (vsync),
    .base_addr   (base_addr),
    .line_offset (line_offset),
    .vaddr       (vaddr),
    .reload_now  (reload_now)
  );

  // fetch FSM state register
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) state <= IDLE;
    else         state <= state_nx;
  end

  // fetch FSM next state; ram_req and LOAD decode straight from the state
  // so both drop the moment reset is asserted
  always_comb begin
    state_nx = state;
    ram_req  = 1'b0;
    LOAD     = 1'b0;
    case (state)
      IDLE: begin
        if (slot_en && (fetch_en || group_open || extra_pend)) state_nx = REQ;
      end
      REQ: begin
        ram_req = 1'b1;
        if (ram_ack) state_nx = LOADH;
      end
      LOADH: begin
        LOAD = 1'b1;
        if (load_last) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // LOAD pulse length counter, running only while LOAD is high
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset)              load_cnt <= '0;
    else if (state == LOADH)  load_cnt <= load_last ? '0 : load_cnt + LCNT_W'(1);
    else                      load_cnt <= '0;
  end

  // fetched word, held stable until the next acknowledge
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset)  DOUT <= '0;
    else if (ack) DOUT <= ram_data;
  end

  // delayed load window for edge and end-of-line detection
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) fetch_en_d <= 1'b0;
    else         fetch_en_d <= fetch_en;
  end

  // plane position within the group and scroll extra-group tracking
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset) begin
      plane_cnt  <= '0;
      extra_pend <= 1'b0;
      extra_grp  <= 1'b0;
    end else if (reload_now) begin
      plane_cnt  <= '0;
      extra_pend <= 1'b0;
      extra_grp  <= 1'b0;
    end else begin
      if (ack) begin
        plane_cnt <= plane_nx;
        if (wrap && (extra_grp || start_extra)) begin
          extra_pend <= 1'b0;
          extra_grp  <= 1'b0;
        end else if (start_extra) begin
          extra_grp  <= 1'b1;
        end
      end
      if (fetch_fall && scroll) extra_pend <= 1'b1;
    end
  end

  // sticky flag: a slot was lost because a fetch was still in flight
  always_ff @(posedge clk32 or negedge nReset) begin
    if (!nReset)                     underrun <= 1'b0;
    else if (slot_en && !idle)       underrun <= 1'b1;
  end

endmodule

// File: tb/tb_shifter_feed.sv
// Scoreboard bench for shifter_feed: stimulus queues the expected fetch
// addresses, a monitor checks each LOAD pulse (data and width).
`timescale 1ns/1ps
module tb_shifter_feed;

  localparam int ADDR_W = 23;
  localparam int OFS_W  = 8;

  logic              clk32 = 1'b0;
  logic              nReset = 1'b0;
  logic              slot_en = 1'b0;
  logic              fetch_en = 1'b0;
  logic              vsync = 1'b0;
  logic [1:0]        rez = 2'd0;
  logic              scroll = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [OFS_W-1:0]  line_offset = '0;
  logic              ram_req;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_ack;
  logic [15:0]       ram_data;
  logic              LOAD;
  logic [15:0]       DOUT;
  logic [ADDR_W-1:0] vaddr;
  logic              underrun;

  int   tests = 0;
  int   fails = 0;
  int   ack_delay = 2;
  logic hold_ack = 1'b0;
  logic force_ack = 1'b0;
  logic [ADDR_W-1:0] exp_q[$];

  shifter_feed #(
    .ADDR_W     (ADDR_W),
    .LOAD_WIDTH (4),
    .OFS_W      (OFS_W)
  ) dut (
    .clk32       (clk32),
    .nReset      (nReset),
    .slot_en     (slot_en),
    .fetch_en    (fetch_en),
    .vsync       (vsync),
    .rez         (rez),
    .scroll      (scroll),
    .base_addr   (base_addr),
    .line_offset (line_offset),
    .ram_req     (ram_req),
    .ram_addr    (ram_addr),
    .ram_ack     (ram_ack),
    .ram_data    (ram_data),
    .LOAD        (LOAD),
    .DOUT        (DOUT),
    .vaddr       (vaddr),
    .underrun    (underrun)
  );

  always #5 clk32 = ~clk32;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // RAM model: acknowledges ack_delay cycles after ram_req with data = addr ^ 0x5A5A
  initial begin
    int wait_cnt;
    wait_cnt = 0;
    ram_ack  = 1'b0;
    ram_data = 16'h0000;
    forever begin
      @(posedge clk32);
      #1;
      ram_ack = force_ack;
      if (ram_req && !hold_ack) begin
        wait_cnt++;
        if (wait_cnt >= ack_delay) begin
          ram_ack  = 1'b1;
          ram_data = ram_addr[15:0] ^ 16'h5A5A;
          wait_cnt = 0;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // monitor: every LOAD rise must match the next queued address; width 4
  initial begin
    logic              prev;
    int                hi;
    logic [ADDR_W-1:0] a;
    prev = 1'b0;
    hi   = 0;
    forever begin
      @(negedge clk32);
      if (LOAD && !prev) begin
        hi = 0;
        if (exp_q.size() == 0) begin
          chk("unexpected_load", 32'(vaddr), 32'hFFFF_FFFF);
        end else begin
          a = exp_q.pop_front();
          chk("dout", 32'(DOUT), 32'(a[15:0] ^ 16'h5A5A));
        end
      end
      if (LOAD) hi++;
      if (!LOAD && prev && nReset) chk("load_width", 32'(hi), 32'd4);
      prev = LOAD;
    end
  end

  task automatic slot();
    @(negedge clk32) slot_en = 1'b1;
    @(negedge clk32) slot_en = 1'b0;
    repeat (15) @(negedge clk32);
  endtask

  task automatic fetch(input logic [ADDR_W-1:0] a);
    exp_q.push_back(a);
    slot();
  endtask

  task automatic frame(input logic [ADDR_W-1:0] b);
    base_addr = b;
    @(negedge clk32) vsync = 1'b1;
    repeat (2) @(negedge clk32);
    vsync = 1'b0;
    repeat (2) @(negedge clk32);
  endtask

  initial begin
    int n;
    // reset state
    @(posedge clk32);
    #1;
    chk("rst_vaddr", 32'(vaddr), 32'h0);
    chk("rst_req", 32'(ram_req), 32'h0);
    chk("rst_load", 32'(LOAD), 32'h0);
    chk("rst_dout", 32'(DOUT), 32'h0);
    chk("rst_underrun", 32'(underrun), 32'h0);
    repeat (2) @(negedge clk32);
    nReset = 1'b1;
    repeat (2) @(negedge clk32);

    // low rez full line of 8 words, no offset
    frame(23'h1000);
    chk("reload_vaddr", 32'(vaddr), 32'h1000);
    fetch_en = 1'b1;
    for (int i = 0; i < 8; i++) fetch(23'h1000 + 23'(i));
    fetch_en = 1'b0;
    repeat (4) @(negedge clk32);
    chk("line1_vaddr", 32'(vaddr), 32'h1008);
    chk("line1_q", 32'(exp_q.size()), 32'd0);

    // window closes mid-group: group completed, then offset 4
    frame(23'h1000);
    line_offset = 8'd4;
    fetch_en = 1'b1;
    for (int i = 0; i < 6; i++) fetch(23'h1000 + 23'(i));
    fetch_en = 1'b0;
    fetch(23'h1006);
    fetch(23'h1007);
    slot();
    chk("line2_vaddr", 32'(vaddr), 32'h100C);
    chk("line2_q", 32'(exp_q.size()), 32'd0);

    // mid rez with hard scroll: one extra group of 2
    rez = 2'd1;
    scroll = 1'b1;
    frame(23'h2000);
    fetch_en = 1'b1;
    for (int i = 0; i < 4; i++) fetch(23'h2000 + 23'(i));
    fetch_en = 1'b0;
    fetch(23'h2004);
    fetch(23'h2005);
    slot();
    scroll = 1'b0;
    chk("scroll_vaddr", 32'(vaddr), 32'h200A);
    chk("scroll_q", 32'(exp_q.size()), 32'd0);

    // vsync during a slow REQ; reload beats the pending line offset
    rez = 2'd0;
    base_addr = 23'h3000;
    fetch_en = 1'b1;
    fetch(23'h200A);
    fetch(23'h200B);
    fetch(23'h200C);
    ack_delay = 5;
    exp_q.push_back(23'h200D);
    @(negedge clk32) slot_en = 1'b1;
    @(negedge clk32) slot_en = 1'b0;
    fetch_en = 1'b0;
    @(negedge clk32) vsync = 1'b1;
    chk("vs_in_req", 32'(ram_req), 32'h1);
    repeat (14) @(negedge clk32);
    vsync = 1'b0;
    chk("vs_vaddr", 32'(vaddr), 32'h3000);
    repeat (10) @(negedge clk32);
    chk("vs_vaddr_hold", 32'(vaddr), 32'h3000);
    chk("vs_q", 32'(exp_q.size()), 32'd0);
    ack_delay = 2;

    // ack held off across a second slot: sticky underrun, slot lost
    fetch_en = 1'b1;
    hold_ack = 1'b1;
    exp_q.push_back(23'h3000);
    @(negedge clk32) slot_en = 1'b1;
    @(negedge clk32) slot_en = 1'b0;
    repeat (3) @(negedge clk32);
    slot_en = 1'b1;
    @(negedge clk32) slot_en = 1'b0;
    chk("underrun_set", 32'(underrun), 32'h1);
    repeat (15) @(negedge clk32);
    hold_ack = 1'b0;
    repeat (10) @(negedge clk32);
    chk("underrun_q", 32'(exp_q.size()), 32'd0);
    fetch(23'h3001);
    fetch(23'h3002);
    fetch(23'h3003);
    fetch_en = 1'b0;
    repeat (4) @(negedge clk32);
    chk("underrun_sticky", 32'(underrun), 32'h1);
    chk("underrun_vaddr", 32'(vaddr), 32'h3008);

    // reset asserted during LOADH, then a stray acknowledge
    fetch_en = 1'b1;
    exp_q.push_back(23'h3008);
    @(negedge clk32) slot_en = 1'b1;
    @(negedge clk32) slot_en = 1'b0;
    fetch_en = 1'b0;
    n = 0;
    while (!LOAD && n < 40) begin
      @(negedge clk32);
      n++;
    end
    chk("rst_load_seen", 32'(LOAD), 32'h1);
    @(posedge clk32);
    #2 nReset = 1'b0;
    #1;
    chk("arst_load", 32'(LOAD), 32'h0);
    chk("arst_req", 32'(ram_req), 32'h0);
    chk("arst_dout", 32'(DOUT), 32'h0);
    chk("arst_vaddr", 32'(vaddr), 32'h0);
    chk("arst_underrun", 32'(underrun), 32'h0);
    repeat (2) @(negedge clk32);
    nReset = 1'b1;
    @(negedge clk32) force_ack = 1'b1;
    @(negedge clk32) force_ack = 1'b0;
    repeat (3) @(negedge clk32);
    chk("stray_req", 32'(ram_req), 32'h0);
    chk("stray_load", 32'(LOAD), 32'h0);
    chk("stray_vaddr", 32'(vaddr), 32'h0);
    chk("stray_dout", 32'(DOUT), 32'h0);
    chk("final_q", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
